// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto one
// shared single-port memory.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous requests go to the side not served last
//   undefined -> simultaneous requests always go to the data side
//
// Handshake: a requester raises iReq/dReq with its command fields stable and
// holds them until the matching ack. Memory completes the command presented
// in a cycle by raising memReady in that same cycle; the arbiter then raises
// the matching ack combinationally for exactly that cycle, with the read data
// on the matching rdata, and returns to IDLE for at least one cycle.
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iReq,
  input  logic [XLEN-1:0] iAddr,
  output logic            iAck,
  output logic [XLEN-1:0] iRdata,
  input  logic            dReq,
  input  logic            dWe,
  input  logic [3:0]      dMask,
  input  logic [XLEN-1:0] dAddr,
  input  logic [XLEN-1:0] dWdata,
  output logic            dAck,
  output logic [XLEN-1:0] dRdata,
  output logic            memEn,
  output logic            memWe,
  output logic [3:0]      memMask,
  output logic [XLEN-1:0] memAddr,
  output logic [XLEN-1:0] memWdata,
  input  logic [XLEN-1:0] memRdata,
  input  logic            memReady,
  output logic            busy,
  output logic [2:0]      debug_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  state_t state;
  state_t pick;
  logic   last_grant;  // 0 = instruction side served last, 1 = data side

  // Winner when both sides request in the same IDLE cycle
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick = last_grant ? IGRANT : DGRANT;
`else
    pick = DGRANT;
`endif
  end

  // Grant FSM and last-served record; reset aborts any open access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iReq && dReq) state <= pick;
          else if (dReq)    state <= DGRANT;
          else if (iReq)    state <= IGRANT;
        end
        IGRANT: begin
          if (memReady) begin
            state      <= IDLE;
            last_grant <= 1'b0;
          end
        end
        DGRANT: begin
          if (memReady) begin
            state      <= IDLE;
            last_grant <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory command, acks and read-data steering decoded from the grant state
  always_comb begin
    memEn    = 1'b0;
    memWe    = 1'b0;
    memMask  = 4'b0000;
    memAddr  = '0;
    memWdata = '0;
    iAck     = 1'b0;
    dAck     = 1'b0;
    iRdata   = '0;
    dRdata   = '0;
    unique case (state)
      IGRANT: begin
        memEn   = 1'b1;
        memMask = 4'b1111;
        memAddr = iAddr;
        iAck    = memReady;
        iRdata  = memReady ? memRdata : '0;
      end
      DGRANT: begin
        memEn    = 1'b1;
        memWe    = dWe;
        memMask  = dMask;
        memAddr  = dAddr;
        memWdata = dWdata;
        dAck     = memReady;
        dRdata   = memReady ? memRdata : '0;
      end
      default: begin
      end
    endcase
  end

  assign busy        = (state != IDLE);
  assign debug_state = {last_grant, state};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized two-requester traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            iReq, dReq, dWe, memReady;
  logic [XLEN-1:0] iAddr, dAddr, dWdata, memRdata;
  logic [3:0]      dMask;
  logic            iAck, dAck, memEn, memWe, busy;
  logic [XLEN-1:0] iRdata, dRdata, memAddr, memWdata;
  logic [3:0]      memMask;
  logic [2:0]      debug_state;

  int n_checks = 0;
  int n_pass   = 0;

  // model: who owns the memory (0 nobody, 1 fetch, 2 data) and who was served last
  int   owner = 0;
  int   last_served = 0;
  logic i_seen = 1'b0, d_seen = 1'b0;
  logic [1:0] exp_q[$];

  mem_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRdata(iRdata),
    .dReq(dReq), .dWe(dWe), .dMask(dMask), .dAddr(dAddr), .dWdata(dWdata),
    .dAck(dAck), .dRdata(dRdata),
    .memEn(memEn), .memWe(memWe), .memMask(memMask), .memAddr(memAddr),
    .memWdata(memWdata), .memRdata(memRdata), .memReady(memReady),
    .busy(busy), .debug_state(debug_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // model update: ownership changes on the clock edge
  always @(posedge clk) begin
    if (reset) begin
      owner = 0;
      last_served = 0;
    end else if (owner == 0) begin
      if (iReq && dReq) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        owner = (last_served == 1) ? 1 : 2;
`else
        owner = 2;
`endif
      end else if (dReq) owner = 2;
      else if (iReq)     owner = 1;
    end else if (memReady) begin
      last_served = (owner == 2) ? 1 : 0;
      owner = 0;
    end
  end

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    logic            e_en, e_we, e_iack, e_dack, e_busy;
    logic [3:0]      e_mask;
    logic [XLEN-1:0] e_addr, e_wdata, e_irdata, e_drdata;
    e_en = 0; e_we = 0; e_iack = 0; e_dack = 0; e_busy = 0;
    e_mask = 0; e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
    if (!reset && owner == 1) begin
      e_en = 1; e_mask = 4'hF; e_addr = iAddr; e_busy = 1;
      e_iack = memReady;
      e_irdata = memReady ? memRdata : 0;
    end else if (!reset && owner == 2) begin
      e_en = 1; e_we = dWe; e_mask = dMask; e_addr = dAddr; e_wdata = dWdata; e_busy = 1;
      e_dack = memReady;
      e_drdata = memReady ? memRdata : 0;
    end
    check("memEn", memEn, e_en);
    check("memWe", memWe, e_we);
    check("memMask", memMask, e_mask);
    check("memAddr", memAddr, e_addr);
    check("memWdata", memWdata, e_wdata);
    check("iAck", iAck, e_iack);
    check("dAck", dAck, e_dack);
    check("iRdata", iRdata, e_irdata);
    check("dRdata", dRdata, e_drdata);
    check("busy", busy, e_busy);
    check("ack_excl", iAck & dAck, 0);
    i_seen = e_iack;
    d_seen = e_dack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; iReq = 0; dReq = 0; dWe = 0; dMask = 0;
    iAddr = 0; dAddr = 0; dWdata = 0; memRdata = 32'hFFFF_FFFF; memReady = 1;

    // reset values with live memory inputs
    @(negedge clk);
    check("rst_memEn", memEn, 0);
    check("rst_busy", busy, 0);
    check("rst_memMask", memMask, 0);
    check("rst_rdata", iRdata | dRdata, 0);
    step();
    reset = 0;

    // single fetch, zero wait states
    iReq = 1; iAddr = 32'h40; memReady = 1; memRdata = 32'hDEAD_BEEF;
    step();
    @(negedge clk);
    check("f_memEn", memEn, 1);
    check("f_memAddr", memAddr, 32'h40);
    check("f_iAck", iAck, 1);
    check("f_iRdata", iRdata, 32'hDEAD_BEEF);
    step();
    iReq = 0;
    @(negedge clk);
    check("f_idle_busy", busy, 0);
    check("f_idle_iRdata", iRdata, 0);

    // data write with three wait states
    dReq = 1; dWe = 1; dMask = 4'b0011; dAddr = 32'h104; dWdata = 32'h1234; memReady = 0;
    step();
    for (int k = 1; k <= 4; k++) begin
      memReady = (k == 4);
      @(negedge clk);
      check("w_busy", busy, 1);
      check("w_memWe", memWe, 1);
      check("w_memMask", memMask, 4'b0011);
      check("w_dAck", dAck, (k == 4));
      step();
    end
    dReq = 0; dWe = 0;
    @(negedge clk);
    check("w_idle_busy", busy, 0);

    // contention: both held for four transactions from a fresh reset
    reset = 1;
    step();
    reset = 0;
    iReq = 1; dReq = 1; iAddr = 32'h80; dAddr = 32'h200; memReady = 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1);
`else
    exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2);
`endif
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (iAck || dAck) begin
        if (exp_q.size() == 0) check("arb_extra_ack", {iAck, dAck}, 0);
        else check("arb_order", dAck ? 2 : 1, exp_q.pop_front());
      end
      step();
    end
    check("arb_acks_left", exp_q.size(), 0);
    iReq = 0; dReq = 0;

    // reset in the middle of a stalled data access
    dReq = 1; dWe = 0; dAddr = 32'h300; memReady = 0;
    step();
    @(negedge clk);
    check("r_memEn_before", memEn, 1);
    #1 reset = 1;
    #1;
    check("r_memEn_async", memEn, 0);
    check("r_busy_async", busy, 0);
    check("r_dAck_async", dAck, 0);
    step();
    reset = 0; memReady = 1;
    @(negedge clk);
    check("r_idle_after", busy, 0);
    step();
    @(negedge clk);
    check("r_regrant_dAck", dAck, 1);
    step();
    dReq = 0;

    // randomized traffic from both requesters
    for (int n = 0; n < 1500; n++) begin
      step();
      if (reset) reset = 0;
      else if ($urandom_range(0, 199) == 0) reset = 1;
      if (iReq && i_seen) iReq = 0;
      if (!iReq && $urandom_range(0, 2) == 0) begin
        iReq = 1;
        iAddr = $urandom;
      end
      if (dReq && d_seen) dReq = 0;
      if (!dReq && $urandom_range(0, 2) == 0) begin
        dReq = 1;
        dWe = $urandom_range(0, 1);
        dMask = 4'($urandom_range(0, 15));
        dAddr = $urandom;
        dWdata = $urandom;
      end
      memReady = ($urandom_range(0, 2) != 0);
      memRdata = $urandom;
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
